sm83_pc_seq: RTL and testbench

Behavioural program-counter sequencer for the SM83 core. It holds the 16-bit PC and performs increment, decrement, two-byte jump loads, RST/interrupt vector loads and a two-cycle push of PC onto the internal data bus. It sits directly upstream of the PC output pulldown cells and supplies the PC bits and the per-byte bus drive strobes that those cells gate onto the address and data buses.

---
 rtl/sm83_pc_seq_if.sv | 31 +++
 rtl/sm83_pc_seq.sv | 133 +++++++++++++
 tb/tb_sm83_pc_seq.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sm83_pc_seq_if.sv
// Request/response bundle between the SM83 control logic and the PC sequencer.
// The master side issues PC requests; the slave side returns the PC and the bus-drive strobes.
interface sm83_pc_seq_if;
    logic        inc;
    logic        dec;
    logic        ld_lo;
    logic        ld_hi;
    logic [7:0]  din;
    logic        rst_vec;
    logic [2:0]  rst_n;
    logic        irq_vec;
    logic [2:0]  irq_n;
    logic        push_req;
    logic [15:0] pc;
    logic [7:0]  dout;
    logic        dbus_hi_oe;
    logic        dbus_lo_oe;
    logic        abus_oe;
    logic        busy;
    logic        err;

    modport master (
        output inc, dec, ld_lo, ld_hi, din, rst_vec, rst_n, irq_vec, irq_n, push_req,
        input  pc, dout, dbus_hi_oe, dbus_lo_oe, abus_oe, busy, err
    );

    modport slave (
        input  inc, dec, ld_lo, ld_hi, din, rst_vec, rst_n, irq_vec, irq_n, push_req,
        output pc, dout, dbus_hi_oe, dbus_lo_oe, abus_oe, busy, err
    );
endinterface

// File: rtl/sm83_pc_seq.sv
// SM83 program-counter sequencer: PC arithmetic, two-byte jump loads, vector loads and
// a two-cycle push of PC onto the internal data bus. All outputs are registered.
//
// state    | meaning
// L_IDLE   | no low jump byte pending
// L_HELD   | low jump byte held in Z, waiting for ld_hi
// P_IDLE   | no push; PC owns the address bus
// P_HI     | pushing PC[15:8] onto the data bus
// P_LO     | pushing PC[7:0] onto the data bus
module sm83_pc_seq #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] IRQ_BASE = 16'h0040
) (
    input  logic                clk,
    input  logic                nreset,
    sm83_pc_seq_if.slave        bus
);

    typedef enum logic { L_IDLE, L_HELD } ld_state_t;
    typedef enum logic [1:0] { P_IDLE, P_HI, P_LO } push_state_t;

    ld_state_t   ld_st, ld_nxt;
    push_state_t p_st, p_nxt;

    logic [15:0] pc_q, pc_nxt;
    logic [7:0]  z_q, z_nxt;
    logic [7:0]  push_lo, lo_nxt;
    logic        err_q, err_nxt;
    logic [7:0]  dout_q, dout_nxt;
    logic        hi_oe_q, lo_oe_q, abus_oe_q, busy_q;

    logic [15:0] irq_addr, rst_addr;

    assign irq_addr = IRQ_BASE + {10'b0, bus.irq_n, 3'b0};
    assign rst_addr = {10'b0, bus.rst_n, 3'b0};

    always_comb begin
        pc_nxt   = pc_q;
        z_nxt    = z_q;
        ld_nxt   = ld_st;
        err_nxt  = err_q;
        p_nxt    = p_st;
        lo_nxt   = push_lo;
        dout_nxt = 8'h00;

        // Vector loads always win and cancel any half-built jump.
        if (bus.irq_vec) begin
            pc_nxt = irq_addr;
            ld_nxt = L_IDLE;
            if (bus.irq_n > 3'd4) err_nxt = 1'b1;
        end else if (bus.rst_vec) begin
            pc_nxt = rst_addr;
            ld_nxt = L_IDLE;
        end else if (bus.ld_hi) begin
            if (ld_st == L_HELD) begin
                pc_nxt = {bus.din, z_q};
                ld_nxt = L_IDLE;
            end else begin
                pc_nxt  = {bus.din, pc_q[7:0]};
                err_nxt = 1'b1;
            end
        end else if (bus.inc && bus.dec) begin
            err_nxt = 1'b1;
        end else if (bus.inc) begin
            pc_nxt = pc_q + 16'd1;
        end else if (bus.dec) begin
            pc_nxt = pc_q - 16'd1;
        end

        if (bus.ld_lo && !bus.irq_vec && !bus.rst_vec && !bus.ld_hi) begin
            z_nxt  = bus.din;
            ld_nxt = L_HELD;
        end

        // The pushed value is the PC seen at acceptance, before this cycle's update.
        case (p_st)
            P_IDLE: begin
                if (bus.push_req) begin
                    p_nxt    = P_HI;
                    lo_nxt   = pc_q[7:0];
                    dout_nxt = pc_q[15:8];
                end
            end
            P_HI: begin
                p_nxt    = P_LO;
                dout_nxt = push_lo;
                if (bus.push_req) err_nxt = 1'b1;
            end
            P_LO: begin
                p_nxt = P_IDLE;
                if (bus.push_req) err_nxt = 1'b1;
            end
            default: p_nxt = P_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pc_q      <= RESET_PC;
            z_q       <= 8'h00;
            push_lo   <= 8'h00;
            ld_st     <= L_IDLE;
            p_st      <= P_IDLE;
            err_q     <= 1'b0;
            dout_q    <= 8'h00;
            hi_oe_q   <= 1'b0;
            lo_oe_q   <= 1'b0;
            abus_oe_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            pc_q      <= pc_nxt;
            z_q       <= z_nxt;
            push_lo   <= lo_nxt;
            ld_st     <= ld_nxt;
            p_st      <= p_nxt;
            err_q     <= err_nxt;
            dout_q    <= dout_nxt;
            hi_oe_q   <= (p_nxt == P_HI);
            lo_oe_q   <= (p_nxt == P_LO);
            abus_oe_q <= (p_nxt == P_IDLE);
            busy_q    <= (ld_nxt == L_HELD) || (p_nxt != P_IDLE);
        end
    end

    assign bus.pc         = pc_q;
    assign bus.dout       = dout_q;
    assign bus.dbus_hi_oe = hi_oe_q;
    assign bus.dbus_lo_oe = lo_oe_q;
    assign bus.abus_oe    = abus_oe_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_sm83_pc_seq.sv
// Self-checking bench for sm83_pc_seq: directed vector table, hand-written push/reset
// sequences and a randomized run against a behavioural model of PC and push behaviour.
module tb_sm83_pc_seq;

    localparam int RESET_PC = 16'h0000;
    localparam int IRQ_BASE = 16'h0040;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    sm83_pc_seq_if bus ();

    sm83_pc_seq #(.RESET_PC(16'h0000), .IRQ_BASE(16'h0040)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: plain integers for PC, plus a queue of the bytes still to be pushed.
    typedef struct { bit hi; bit lo; int data; } push_rec_t;
    int        m_pc;
    int        m_z;
    bit        m_pending;
    bit        m_err;
    bit        m_cur_valid;
    push_rec_t m_cur;
    push_rec_t m_rest[$];

    typedef struct {
        bit inc, dec, ld_lo, ld_hi;
        int din;
        bit rst_vec;
        int rst_n;
        bit irq_vec;
        int irq_n;
        bit push_req;
        int exp_pc;
        bit exp_busy;
        bit exp_err;
    } vec_t;

    function automatic vec_t mk(bit inc, bit dec, bit ld_lo, bit ld_hi, int din,
                                bit rst_vec, int rst_n, bit irq_vec, int irq_n, bit push_req,
                                int exp_pc, bit exp_busy, bit exp_err);
        vec_t v;
        v.inc = inc; v.dec = dec; v.ld_lo = ld_lo; v.ld_hi = ld_hi; v.din = din;
        v.rst_vec = rst_vec; v.rst_n = rst_n; v.irq_vec = irq_vec; v.irq_n = irq_n;
        v.push_req = push_req; v.exp_pc = exp_pc; v.exp_busy = exp_busy; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(vec_t v);
        bus.inc = v.inc; bus.dec = v.dec; bus.ld_lo = v.ld_lo; bus.ld_hi = v.ld_hi;
        bus.din = v.din[7:0]; bus.rst_vec = v.rst_vec; bus.rst_n = v.rst_n[2:0];
        bus.irq_vec = v.irq_vec; bus.irq_n = v.irq_n[2:0]; bus.push_req = v.push_req;
    endtask

    task automatic idle_inputs();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_z = 0; m_pending = 0; m_err = 0; m_cur_valid = 0;
        m_rest.delete();
    endtask

    task automatic model_edge();
        int old_pc;
        push_rec_t r;
        old_pc = m_pc;
        if (!m_cur_valid) begin
            if (bus.push_req) begin
                m_cur = '{hi: 1, lo: 0, data: old_pc / 256};
                r = '{hi: 0, lo: 1, data: old_pc % 256};
                m_rest.push_back(r);
                m_cur_valid = 1;
            end
        end else begin
            if (bus.push_req) m_err = 1;
            if (m_rest.size() > 0) m_cur = m_rest.pop_front();
            else m_cur_valid = 0;
        end
        if (bus.irq_vec) begin
            m_pc = IRQ_BASE + 8 * int'(bus.irq_n);
            if (bus.irq_n > 4) m_err = 1;
            m_pending = 0;
        end else if (bus.rst_vec) begin
            m_pc = 8 * int'(bus.rst_n);
            m_pending = 0;
        end else if (bus.ld_hi) begin
            if (m_pending) begin
                m_pc = 256 * int'(bus.din) + m_z;
                m_pending = 0;
            end else begin
                m_pc = 256 * int'(bus.din) + (old_pc % 256);
                m_err = 1;
            end
        end else if (bus.inc && bus.dec) begin
            m_err = 1;
        end else if (bus.inc) begin
            m_pc = (old_pc + 1) % 65536;
        end else if (bus.dec) begin
            m_pc = (old_pc + 65535) % 65536;
        end
        if (bus.ld_lo && !bus.irq_vec && !bus.rst_vec && !bus.ld_hi) begin
            m_z = int'(bus.din);
            m_pending = 1;
        end
    endtask

    task automatic compare_all(string tag);
        check({tag, ".pc"},    int'(bus.pc),         m_pc);
        check({tag, ".dout"},  int'(bus.dout),       m_cur_valid ? m_cur.data : 0);
        check({tag, ".hi_oe"}, int'(bus.dbus_hi_oe), int'(m_cur_valid && m_cur.hi));
        check({tag, ".lo_oe"}, int'(bus.dbus_lo_oe), int'(m_cur_valid && m_cur.lo));
        check({tag, ".abus"},  int'(bus.abus_oe),    int'(!m_cur_valid));
        check({tag, ".busy"},  int'(bus.busy),       int'(m_pending || m_cur_valid));
        check({tag, ".err"},   int'(bus.err),        int'(m_err));
    endtask

    task automatic step(string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        nreset = 1'b0;
        model_reset();
        #1;
        compare_all("reset");
        @(negedge clk);
        nreset = 1'b1;
    endtask

    vec_t tbl[$];
    int   hi_cnt, lo_cnt;

    initial begin
        idle_inputs();
        model_reset();
        do_reset();

        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 16'h0001, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 16'h0002, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 16'h0003, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 8'hFF, 0, 0, 0, 0, 0, 16'h0003, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 16'hFFFF, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 16'hFFFF, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 8'h34, 0, 0, 0, 0, 0, 16'hFFFF, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 16'hFFFF, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 16'hFFFF, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'h12, 0, 0, 0, 0, 0, 16'h1234, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'hAB, 0, 0, 0, 0, 0, 16'hAB34, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 8'h99, 0, 0, 0, 0, 0, 16'hAB34, 1, 1));
        tbl.push_back(mk(1, 0, 0, 1, 8'h11, 1, 5, 1, 2, 0, 16'h0050, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 8'h77, 0, 0, 0, 0, 0, 16'h7750, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 3, 0, 0, 0, 16'h0018, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 16'h0018, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            step("tbl");
            check($sformatf("tbl%0d.pc", i),   int'(bus.pc),   tbl[i].exp_pc);
            check($sformatf("tbl%0d.busy", i), int'(bus.busy), int'(tbl[i].exp_busy));
            check($sformatf("tbl%0d.err", i),  int'(bus.err),  int'(tbl[i].exp_err));
            idle_inputs();
        end

        // inc and dec together leave PC alone and flag err from a clean state.
        do_reset();
        drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("incdec");
        check("incdec.pc", int'(bus.pc), 16'h0000);
        check("incdec.err", int'(bus.err), 1);

        do_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0));
        step("irq7");
        check("irq7.pc", int'(bus.pc), 16'h0078);
        check("irq7.err", int'(bus.err), 1);

        // Push with a same-cycle increment: pushed bytes are the pre-increment PC.
        do_reset();
        drive(mk(0, 0, 1, 0, 8'hEF, 0, 0, 0, 0, 0, 0, 0, 0)); step("beef_lo");
        drive(mk(0, 0, 0, 1, 8'hBE, 0, 0, 0, 0, 0, 0, 0, 0)); step("beef_hi");
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        step("push1");
        idle_inputs();
        check("push1.hi_oe", int'(bus.dbus_hi_oe), 1);
        check("push1.dout", int'(bus.dout), 8'hBE);
        check("push1.abus", int'(bus.abus_oe), 0);
        step("push2");
        check("push2.lo_oe", int'(bus.dbus_lo_oe), 1);
        check("push2.dout", int'(bus.dout), 8'hEF);
        check("push2.abus", int'(bus.abus_oe), 0);
        check("push2.pc", int'(bus.pc), 16'hBEF0);
        step("push3");
        check("push3.abus", int'(bus.abus_oe), 1);
        check("push3.dout", int'(bus.dout), 0);
        check("push3.err", int'(bus.err), 0);

        // push_req held for three cycles: one sequence only, err set.
        do_reset();
        hi_cnt = 0; lo_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            bus.push_req = (i < 3);
            step("hold");
            hi_cnt += int'(bus.dbus_hi_oe);
            lo_cnt += int'(bus.dbus_lo_oe);
        end
        check("hold.hi_count", hi_cnt, 1);
        check("hold.lo_count", lo_cnt, 1);
        check("hold.err", int'(bus.err), 1);

        // Asynchronous reset in the middle of PHI.
        do_reset();
        drive(mk(0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0)); step("pre_rst");
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); step("phi");
        idle_inputs();
        check("phi.hi_oe", int'(bus.dbus_hi_oe), 1);
        #2;
        nreset = 1'b0;
        model_reset();
        #1;
        check("midrst.pc", int'(bus.pc), RESET_PC);
        check("midrst.hi_oe", int'(bus.dbus_hi_oe), 0);
        check("midrst.dout", int'(bus.dout), 0);
        check("midrst.abus", int'(bus.abus_oe), 1);
        check("midrst.busy", int'(bus.busy), 0);
        @(negedge clk);
        nreset = 1'b1;
        step("postrst");

        // Randomized run against the model, with periodic resets to re-arm err.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) do_reset();
            bus.inc      = ($urandom % 4) == 0;
            bus.dec      = ($urandom % 5) == 0;
            bus.ld_lo    = ($urandom % 5) == 0;
            bus.ld_hi    = ($urandom % 6) == 0;
            bus.din      = 8'($urandom);
            bus.rst_vec  = ($urandom % 14) == 0;
            bus.rst_n    = 3'($urandom);
            bus.irq_vec  = ($urandom % 16) == 0;
            bus.irq_n    = ($urandom % 8) < 6 ? 3'($urandom_range(0, 4)) : 3'($urandom);
            bus.push_req = ($urandom % 5) == 0;
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
